// File: rtl/dcp_txn_tracker.sv
// dcp_txn_tracker: passive outstanding-transaction scoreboard for NUM_CH request/response
// channels, with per-ID counts, per-channel totals, watchdogs and first-error capture.
module dcp_txn_tracker #(
  parameter  int NUM_CH  = 4,
  parameter  int ID_W    = 3,
  parameter  int CNT_W   = 2,
  parameter  int TMO_W   = 10,
  parameter  int TIMEOUT = 1000,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TOT_W   = ID_W + CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clr_err,
  input  logic [NUM_CH-1:0]         req_val,
  input  logic [NUM_CH-1:0]         req_rdy,
  input  logic [NUM_CH*ID_W-1:0]    req_id,
  input  logic [NUM_CH-1:0]         rsp_val,
  input  logic [NUM_CH-1:0]         rsp_rdy,
  input  logic [NUM_CH*ID_W-1:0]    rsp_id,
  input  logic                      qry_val,
  input  logic [CH_W-1:0]           qry_ch,
  input  logic [ID_W-1:0]           qry_id,
  output logic                      qry_rsp_val,
  output logic [CNT_W-1:0]          qry_cnt,
  output logic [NUM_CH*TOT_W-1:0]   out_total,
  output logic [NUM_CH-1:0]         err_unexp,
  output logic [NUM_CH-1:0]         err_ovf,
  output logic [NUM_CH-1:0]         err_tmo,
  output logic                      err_any,
  output logic [1:0]                err_first_code,
  output logic [CH_W-1:0]           err_first_ch,
  output logic [ID_W-1:0]           err_first_id,
  output logic                      idle
);

  localparam int                NUM_ID  = 1 << ID_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt       [NUM_CH][NUM_ID];
  logic [CNT_W-1:0] cnt_nxt   [NUM_CH][NUM_ID];
  logic [TOT_W-1:0] total     [NUM_CH];
  logic [TOT_W-1:0] total_nxt [NUM_CH];
  logic [TMO_W-1:0] wd        [NUM_CH];
  logic [TMO_W-1:0] wd_nxt    [NUM_CH];
  logic [ID_W-1:0]  rid       [NUM_CH];
  logic [ID_W-1:0]  sid       [NUM_CH];
  logic [NUM_CH-1:0] req_hsk, rsp_hsk;
  logic [NUM_CH-1:0] new_unexp, new_ovf, new_tmo;
  logic              idle_nxt;
  logic [1:0]        code_nxt;
  logic [CH_W-1:0]   fch_nxt;
  logic [ID_W-1:0]   fid_nxt;
  logic [CNT_W-1:0]  qry_cnt_nxt;

  assign req_hsk = req_val & req_rdy;
  assign rsp_hsk = rsp_val & rsp_rdy;
  assign err_any = |{err_unexp, err_ovf, err_tmo};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign rid[c] = req_id[c*ID_W +: ID_W];
    assign sid[c] = rsp_id[c*ID_W +: ID_W];
    assign out_total[c*TOT_W +: TOT_W] = total[c];
  end

  // A request and response on the same ID in one cycle cancel (pass-through).
  always_comb begin
    cnt_nxt   = cnt;
    total_nxt = total;
    wd_nxt    = wd;
    new_unexp = '0;
    new_ovf   = '0;
    new_tmo   = '0;
    if (enable) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!(req_hsk[c] && rsp_hsk[c] && rid[c] == sid[c])) begin
          if (req_hsk[c]) begin
            if (cnt[c][rid[c]] == CNT_MAX) begin
              new_ovf[c] = 1'b1;
            end else begin
              cnt_nxt[c][rid[c]] = cnt[c][rid[c]] + 1'b1;
              total_nxt[c]       = total_nxt[c] + 1'b1;
            end
          end
          if (rsp_hsk[c]) begin
            if (cnt[c][sid[c]] == '0) begin
              new_unexp[c] = 1'b1;
            end else begin
              cnt_nxt[c][sid[c]] = cnt[c][sid[c]] - 1'b1;
              total_nxt[c]       = total_nxt[c] - 1'b1;
            end
          end
        end
        if (rsp_hsk[c] || total[c] == '0) begin
          wd_nxt[c] = '0;
        end else if (wd[c] != TMO_LIM) begin
          wd_nxt[c]  = wd[c] + 1'b1;
          new_tmo[c] = (wd[c] == TMO_LIM - 1'b1);
        end
      end
    end
    idle_nxt = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (total_nxt[c] != '0) idle_nxt = 1'b0;
    end
  end

  // First-error capture: lowest channel wins, then unexp > ovf > tmo.
  always_comb begin
    logic open;
    code_nxt = clr_err ? 2'd0 : err_first_code;
    fch_nxt  = clr_err ? '0 : err_first_ch;
    fid_nxt  = clr_err ? '0 : err_first_id;
    open     = (code_nxt == 2'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (open) begin
        if (new_unexp[c]) begin
          open = 1'b0; code_nxt = 2'd1; fch_nxt = CH_W'(c); fid_nxt = sid[c];
        end else if (new_ovf[c]) begin
          open = 1'b0; code_nxt = 2'd2; fch_nxt = CH_W'(c); fid_nxt = rid[c];
        end else if (new_tmo[c]) begin
          open = 1'b0; code_nxt = 2'd3; fch_nxt = CH_W'(c); fid_nxt = '0;
        end
      end
    end
  end

  always_comb begin
    qry_cnt_nxt = '0;
    if (int'(qry_ch) < NUM_CH) qry_cnt_nxt = cnt_nxt[qry_ch][qry_id];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NUM_ID; i++) cnt[c][i] <= '0;
        total[c] <= '0;
        wd[c]    <= '0;
      end
      err_unexp      <= '0;
      err_ovf        <= '0;
      err_tmo        <= '0;
      err_first_code <= 2'd0;
      err_first_ch   <= '0;
      err_first_id   <= '0;
      qry_rsp_val    <= 1'b0;
      qry_cnt        <= '0;
      idle           <= 1'b1;
    end else begin
      cnt            <= cnt_nxt;
      total          <= total_nxt;
      wd             <= wd_nxt;
      err_unexp      <= (clr_err ? '0 : err_unexp) | new_unexp;
      err_ovf        <= (clr_err ? '0 : err_ovf)   | new_ovf;
      err_tmo        <= (clr_err ? '0 : err_tmo)   | new_tmo;
      err_first_code <= code_nxt;
      err_first_ch   <= fch_nxt;
      err_first_id   <= fid_nxt;
      qry_rsp_val    <= qry_val;
      qry_cnt        <= qry_cnt_nxt;
      idle           <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_dcp_txn_tracker.sv
// Bench for dcp_txn_tracker: directed scenarios plus random traffic against a
// count/stall reference model; query results flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_dcp_txn_tracker;
  localparam int NUM_CH = 4, ID_W = 3, CNT_W = 2, TMO_W = 10, TIMEOUT = 1000;
  localparam int NID = 8, CMAX = 3, TOT_W = 5;

  logic clk = 0, rst = 1, enable = 1, clr_err = 0;
  logic [NUM_CH-1:0] req_val = '0, req_rdy = '1, rsp_val = '0, rsp_rdy = '1;
  logic [NUM_CH*ID_W-1:0] req_id = '0, rsp_id = '0;
  logic qry_val = 0;
  logic [1:0] qry_ch = '0;
  logic [ID_W-1:0] qry_id = '0;
  logic qry_rsp_val, err_any, idle;
  logic [CNT_W-1:0] qry_cnt;
  logic [NUM_CH*TOT_W-1:0] out_total;
  logic [NUM_CH-1:0] err_unexp, err_ovf, err_tmo;
  logic [1:0] err_first_code, err_first_ch;
  logic [ID_W-1:0] err_first_id;

  dcp_txn_tracker #(.NUM_CH(NUM_CH), .ID_W(ID_W), .CNT_W(CNT_W), .TMO_W(TMO_W),
                    .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .req_val(req_val), .req_rdy(req_rdy), .req_id(req_id),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
    .qry_val(qry_val), .qry_ch(qry_ch), .qry_id(qry_id),
    .qry_rsp_val(qry_rsp_val), .qry_cnt(qry_cnt), .out_total(out_total),
    .err_unexp(err_unexp), .err_ovf(err_ovf), .err_tmo(err_tmo), .err_any(err_any),
    .err_first_code(err_first_code), .err_first_ch(err_first_ch),
    .err_first_id(err_first_id), .idle(idle));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_cnt[NUM_CH][NID];
  int m_wd[NUM_CH];
  bit [NUM_CH-1:0] m_u, m_o, m_t;
  int m_code, m_ch, m_id;
  bit exp_qv;
  int q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int ch_sum(input int c);
    int s = 0;
    for (int i = 0; i < NID; i++) s += m_cnt[c][i];
    return s;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NID; i++) m_cnt[c][i] = 0;
      m_wd[c] = 0;
    end
    m_u = '0; m_o = '0; m_t = '0;
    m_code = 0; m_ch = 0; m_id = 0; exp_qv = 0;
  endtask

  // Reference: computes the state expected just after the coming clock edge.
  task automatic model_step();
    bit [NUM_CH-1:0] nu, no, nt;
    int uid[NUM_CH], oid[NUM_CH], tb4[NUM_CH];
    nu = '0; no = '0; nt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tb4[c] = ch_sum(c); uid[c] = 0; oid[c] = 0;
    end
    if (enable) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit rq, rs;
        int a, b;
        rq = req_val[c] & req_rdy[c];
        rs = rsp_val[c] & rsp_rdy[c];
        a  = int'(req_id[c*ID_W +: ID_W]);
        b  = int'(rsp_id[c*ID_W +: ID_W]);
        oid[c] = a; uid[c] = b;
        if (!(rq && rs && a == b)) begin
          if (rq) begin
            if (m_cnt[c][a] == CMAX) no[c] = 1; else m_cnt[c][a]++;
          end
          if (rs) begin
            if (m_cnt[c][b] == 0) nu[c] = 1; else m_cnt[c][b]--;
          end
        end
        if (rs || tb4[c] == 0) m_wd[c] = 0;
        else if (m_wd[c] < TIMEOUT) begin
          m_wd[c]++;
          if (m_wd[c] == TIMEOUT) nt[c] = 1;
        end
      end
    end
    if (clr_err) begin
      m_u = '0; m_o = '0; m_t = '0; m_code = 0; m_ch = 0; m_id = 0;
    end
    m_u |= nu; m_o |= no; m_t |= nt;
    if (m_code == 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_code == 0) begin
          if (nu[c])      begin m_code = 1; m_ch = c; m_id = uid[c]; end
          else if (no[c]) begin m_code = 2; m_ch = c; m_id = oid[c]; end
          else if (nt[c]) begin m_code = 3; m_ch = c; m_id = 0; end
        end
      end
    end
    exp_qv = qry_val;
    if (qry_val) q.push_back(m_cnt[qry_ch][qry_id]);
  endtask

  task automatic check_all();
    bit all_zero = 1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("out_total", 32'(out_total[c*TOT_W +: TOT_W]), ch_sum(c));
      if (ch_sum(c) != 0) all_zero = 0;
    end
    chk("err_unexp", 32'(err_unexp), 32'(m_u));
    chk("err_ovf", 32'(err_ovf), 32'(m_o));
    chk("err_tmo", 32'(err_tmo), 32'(m_t));
    chk("err_any", 32'(err_any), 32'(|{m_u, m_o, m_t}));
    chk("first_code", 32'(err_first_code), m_code);
    chk("first_ch", 32'(err_first_ch), m_ch);
    chk("first_id", 32'(err_first_id), m_id);
    chk("idle", 32'(idle), 32'(all_zero));
    chk("qry_rsp_val", 32'(qry_rsp_val), 32'(exp_qv));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check_all();
    req_val = '0; rsp_val = '0; qry_val = 0; clr_err = 0;
  endtask

  task automatic req1(input int ch, input int id);
    req_val[ch] = 1; req_id[ch*ID_W +: ID_W] = ID_W'(id);
  endtask
  task automatic rsp1(input int ch, input int id);
    rsp_val[ch] = 1; rsp_id[ch*ID_W +: ID_W] = ID_W'(id);
  endtask
  task automatic qry1(input int ch, input int id);
    qry_val = 1; qry_ch = 2'(ch); qry_id = ID_W'(id);
  endtask

  // Scoreboard monitor: each presented query result is matched to the oldest expectation.
  initial begin
    int e;
    forever begin
      @(posedge clk); #1;
      if (qry_rsp_val) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL qry_unexpected at %0t: got response, expected none", $time);
        end else begin
          e = q.pop_front();
          chk("qry_cnt", 32'(qry_cnt), e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all();

    // Ch0 up/down with queries tracking the count.
    for (int k = 0; k < 3; k++) begin req1(0, 3); qry1(0, 3); tick(); end
    for (int k = 0; k < 3; k++) begin rsp1(0, 3); qry1(0, 3); tick(); end
    chk("ch0_drained_idle", 32'(idle), 1);

    // Ch1 unexpected response.
    rsp1(1, 5); tick();
    chk("unexp_first_ch", 32'(err_first_ch), 1);
    chk("unexp_first_id", 32'(err_first_id), 5);
    clr_err = 1; tick();

    // Ch2 saturation.
    for (int k = 0; k < 4; k++) begin req1(2, 1); tick(); end
    qry1(2, 1); tick();
    chk("ovf_flag", 32'(err_ovf[2]), 1);
    for (int k = 0; k < 3; k++) begin rsp1(2, 1); tick(); end
    clr_err = 1; tick();

    // Ch0 watchdog.
    req1(0, 2); tick();
    repeat (TIMEOUT - 1) tick();
    chk("tmo_not_yet", 32'(err_tmo[0]), 0);
    tick();
    chk("tmo_fired", 32'(err_tmo[0]), 1);
    repeat (20) tick();
    rsp1(0, 2); tick();
    clr_err = 1; tick();
    chk("err_any_cleared", 32'(err_any), 0);

    // Pass-through on ch3, then simultaneous unexp on ch0/ch2.
    req1(3, 0); rsp1(3, 0); qry1(3, 0); tick();
    rsp1(0, 1); rsp1(2, 6); tick();
    chk("prio_first_ch", 32'(err_first_ch), 0);
    // clr_err with a new error in the same cycle: new error is recorded.
    clr_err = 1; req1(1, 7); rsp1(3, 2); tick();
    clr_err = 1; tick();

    // Query after two requests, then reset mid-traffic.
    req1(1, 4); tick();
    req1(1, 4); tick();
    qry1(1, 4); tick();
    repeat (3) @(posedge clk);
    #1;
    req1(2, 5); rsp1(0, 3);
    #2 rst = 1;
    #1;
    model_clear();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 0;
    req_val = '0; rsp_val = '0;
    rsp1(1, 4); tick();

    // Random traffic, narrow ID range to force collisions and saturation.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        req_val[c] = ($urandom_range(0, 2) == 0);
        req_rdy[c] = ($urandom_range(0, 3) != 0);
        rsp_val[c] = ($urandom_range(0, 2) == 0);
        rsp_rdy[c] = ($urandom_range(0, 3) != 0);
        req_id[c*ID_W +: ID_W] = ID_W'($urandom_range(0, 3));
        rsp_id[c*ID_W +: ID_W] = ID_W'($urandom_range(0, 3));
      end
      enable  = ($urandom_range(0, 15) != 0);
      clr_err = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1) qry1($urandom_range(0, 3), $urandom_range(0, 7));
      tick();
    end
    enable = 1; req_rdy = '1; rsp_rdy = '1;
    repeat (2) tick();
    chk("qry_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
